gpio_bus_arbiter: RTL and testbench



---
 rtl/gpio_bus_arbiter_if.sv | 49 ++++
 rtl/gpio_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_arbiter_if.sv
// Requester and SoC-bus signal bundle for gpio_bus_arbiter.
// slave = arbiter side, master = requesters / bus environment side.
interface gpio_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_wr_en;
    logic          bus_rd_en;
    logic [DW-1:0] bus_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output bus_addr, bus_wdata, bus_wr_en, bus_rd_en,
        input  bus_rdata,
        output busy, owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  bus_addr, bus_wdata, bus_wr_en, bus_rd_en,
        output bus_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Two-requester arbiter for the GPIO bus: one transaction at a time, fixed read latency.
// Define GPIO_ARB_FIXED_PRI_EN for fixed priority (m0 wins ties); default is round-robin.
module gpio_bus_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic                clk,
    input  logic                rst,
    gpio_bus_arbiter_if.slave   arb
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]    state_reg;
    logic [3:0]    cnt_reg;
    logic          owner_reg;
    logic          we_reg;
    logic [AW-1:0] bus_addr_reg;
    logic [DW-1:0] bus_wdata_reg;
    logic          bus_wr_en_reg;
    logic          bus_rd_en_reg;
    logic [1:0]    ack_reg;
    logic [DW-1:0] rdata_reg [2];

    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];
    logic          grant_idx;
    logic          grant_valid;
    logic          ack_fire;

    assign req_vec      = {arb.m1_req, arb.m0_req};
    assign we_vec       = {arb.m1_we, arb.m0_we};
    assign addr_vec[0]  = arb.m0_addr;
    assign addr_vec[1]  = arb.m1_addr;
    assign wdata_vec[0] = arb.m0_wdata;
    assign wdata_vec[1] = arb.m1_wdata;

    assign grant_valid = (state_reg == ST_IDLE) && (|req_vec);

`ifdef GPIO_ARB_FIXED_PRI_EN
    assign grant_idx = ~req_vec[0];
`else
    logic last_owner_reg;

    // On a tie the requester that did not win last time gets the bus.
    assign grant_idx = (&req_vec) ? ~last_owner_reg : ~req_vec[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= 1'b1;
        end else if (grant_valid) begin
            last_owner_reg <= grant_idx;
        end
    end
`endif

    // cnt counts down from RD_LAT starting in the strobe cycle; at 1 the read
    // data is sampled and the ack is raised, at 0 (the ack cycle) we go idle.
    assign ack_fire = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) && (cnt_reg == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            owner_reg     <= 1'b0;
            we_reg        <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_wr_en_reg <= 1'b0;
            bus_rd_en_reg <= 1'b0;
        end else begin
            bus_wr_en_reg <= 1'b0;
            bus_rd_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_reg     <= grant_idx;
                        we_reg        <= we_vec[grant_idx];
                        bus_addr_reg  <= addr_vec[grant_idx];
                        bus_wdata_reg <= wdata_vec[grant_idx];
                        bus_wr_en_reg <= we_vec[grant_idx];
                        bus_rd_en_reg <= ~we_vec[grant_idx];
                        cnt_reg       <= 4'(RD_LAT);
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= cnt_reg - 4'd1;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 4'd0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_reg[gi]   <= 1'b0;
                    rdata_reg[gi] <= '0;
                end else begin
                    ack_reg[gi] <= ack_fire && (owner_reg == 1'(gi));
                    if (ack_fire && (owner_reg == 1'(gi)) && !we_reg) begin
                        rdata_reg[gi] <= arb.bus_rdata;
                    end
                end
            end
        end
    endgenerate

    assign arb.m0_ack    = ack_reg[0];
    assign arb.m1_ack    = ack_reg[1];
    assign arb.m0_rdata  = rdata_reg[0];
    assign arb.m1_rdata  = rdata_reg[1];
    assign arb.bus_addr  = bus_addr_reg;
    assign arb.bus_wdata = bus_wdata_reg;
    assign arb.bus_wr_en = bus_wr_en_reg;
    assign arb.bus_rd_en = bus_rd_en_reg;
    assign arb.busy      = (state_reg != ST_IDLE);
    assign arb.owner     = owner_reg;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: one DUT with RD_LAT=1, one with RD_LAT=3.
module tb_gpio_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    gpio_bus_arbiter_if #(.AW(32), .DW(32)) if1 ();
    gpio_bus_arbiter_if #(.AW(32), .DW(32)) if3 ();

    gpio_bus_arbiter #(.RD_LAT(1), .AW(32), .DW(32)) u_dut1 (.clk(clk), .rst(rst), .arb(if1));
    gpio_bus_arbiter #(.RD_LAT(3), .AW(32), .DW(32)) u_dut3 (.clk(clk), .rst(rst), .arb(if3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({if1.busy, if1.owner, if1.bus_wr_en, if1.bus_rd_en, if1.m0_ack, if1.m1_ack} !== 6'b0)
            $display("FAIL reset_flags1: got %b want 000000", {if1.busy, if1.owner, if1.bus_wr_en, if1.bus_rd_en, if1.m0_ack, if1.m1_ack});
        else n_pass++;
        n_checks++;
        if ({if1.bus_addr, if1.bus_wdata} !== 64'h0)
            $display("FAIL reset_bus1: got %h want 0", {if1.bus_addr, if1.bus_wdata});
        else n_pass++;
        n_checks++;
        if ({if1.m0_rdata, if1.m1_rdata} !== 64'h0)
            $display("FAIL reset_rdata1: got %h want 0", {if1.m0_rdata, if1.m1_rdata});
        else n_pass++;
        n_checks++;
        if ({if3.busy, if3.owner, if3.bus_wr_en, if3.bus_rd_en, if3.m0_ack, if3.m1_ack} !== 6'b0)
            $display("FAIL reset_flags3: got %b want 000000", {if3.busy, if3.owner, if3.bus_wr_en, if3.bus_rd_en, if3.m0_ack, if3.m1_ack});
        else n_pass++;
        $display("txn reset: done");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        if1.m0_req = 1'b1; if1.m0_we = 1'b1;
        if1.m0_addr = 32'h4000_0004; if1.m0_wdata = 32'hA5A5_0001;
        tick();
        n_checks++;
        if ({if1.bus_wr_en, if1.bus_rd_en} !== 2'b10)
            $display("FAIL write_strobe: got %b want 10", {if1.bus_wr_en, if1.bus_rd_en});
        else n_pass++;
        n_checks++;
        if (if1.bus_addr !== 32'h4000_0004)
            $display("FAIL write_addr: got %h want 40000004", if1.bus_addr);
        else n_pass++;
        n_checks++;
        if (if1.bus_wdata !== 32'hA5A5_0001)
            $display("FAIL write_wdata: got %h want a5a50001", if1.bus_wdata);
        else n_pass++;
        n_checks++;
        if ({if1.busy, if1.owner, if1.m0_ack} !== 3'b100)
            $display("FAIL write_busy_owner_ack: got %b want 100", {if1.busy, if1.owner, if1.m0_ack});
        else n_pass++;
        tick();
        n_checks++;
        if ({if1.bus_wr_en, if1.m0_ack, if1.m1_ack} !== 3'b010)
            $display("FAIL write_ack: got %b want 010", {if1.bus_wr_en, if1.m0_ack, if1.m1_ack});
        else n_pass++;
        n_checks++;
        if (if1.bus_addr !== 32'h4000_0004)
            $display("FAIL write_addr_hold: got %h want 40000004", if1.bus_addr);
        else n_pass++;
        if1.m0_req = 1'b0;
        tick();
        n_checks++;
        if ({if1.busy, if1.m0_ack} !== 2'b00)
            $display("FAIL write_idle: got %b want 00", {if1.busy, if1.m0_ack});
        else n_pass++;
        $display("txn write m0: addr=%h wdata=%h", if1.bus_addr, if1.bus_wdata);
    endtask

    task automatic test_read();
        if1.bus_rdata = 32'h0000_00F0;
        if1.m1_req = 1'b1; if1.m1_we = 1'b0; if1.m1_addr = 32'h4000_0008;
        tick();
        n_checks++;
        if ({if1.bus_wr_en, if1.bus_rd_en, if1.owner} !== 3'b011)
            $display("FAIL read_strobe_owner: got %b want 011", {if1.bus_wr_en, if1.bus_rd_en, if1.owner});
        else n_pass++;
        tick();
        n_checks++;
        if ({if1.m1_ack, if1.m0_ack} !== 2'b10)
            $display("FAIL read_ack: got %b want 10", {if1.m1_ack, if1.m0_ack});
        else n_pass++;
        n_checks++;
        if (if1.m1_rdata !== 32'h0000_00F0)
            $display("FAIL read_rdata: got %h want 000000f0", if1.m1_rdata);
        else n_pass++;
        n_checks++;
        if (if1.m0_rdata !== 32'h0)
            $display("FAIL read_other_rdata: got %h want 0", if1.m0_rdata);
        else n_pass++;
        if1.m1_req = 1'b0;
        tick();
        $display("txn read m1: rdata=%h", if1.m1_rdata);
    endtask

    task automatic test_round_robin();
        logic exp_owner [4];
        bit   found;
`ifdef GPIO_ARB_FIXED_PRI_EN
        exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_owner = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        if1.m0_req = 1'b1; if1.m0_we = 1'b1; if1.m0_addr = 32'h100; if1.m0_wdata = 32'hA0;
        if1.m1_req = 1'b1; if1.m1_we = 1'b1; if1.m1_addr = 32'h200; if1.m1_wdata = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
                tick();
                if (if1.bus_wr_en) found = 1'b1;
            end
            n_checks++;
            if (!found) $display("FAIL rr_strobe_timeout: txn %0d got none want strobe", i);
            else n_pass++;
            n_checks++;
            if (if1.owner !== exp_owner[i])
                $display("FAIL rr_owner: txn %0d got %b want %b", i, if1.owner, exp_owner[i]);
            else n_pass++;
            n_checks++;
            if (if1.bus_addr !== (exp_owner[i] ? 32'h200 : 32'h100))
                $display("FAIL rr_addr: txn %0d got %h want %h", i, if1.bus_addr, exp_owner[i] ? 32'h200 : 32'h100);
            else n_pass++;
            if (i == 3) begin
                if1.m0_req = 1'b0;
                if1.m1_req = 1'b0;
            end
            tick();
            n_checks++;
            if ({if1.m1_ack, if1.m0_ack} !== (exp_owner[i] ? 2'b10 : 2'b01))
                $display("FAIL rr_ack: txn %0d got %b want %b", i, {if1.m1_ack, if1.m0_ack}, exp_owner[i] ? 2'b10 : 2'b01);
            else n_pass++;
            $display("txn rr %0d: owner=%b addr=%h", i, if1.owner, if1.bus_addr);
        end
        tick();
        tick();
    endtask

    task automatic test_latency3();
        if3.bus_rdata = 32'h0;
        if3.m0_req = 1'b1; if3.m0_we = 1'b0; if3.m0_addr = 32'h4000_0010;
        tick();
        n_checks++;
        if ({if3.bus_wr_en, if3.bus_rd_en} !== 2'b01)
            $display("FAIL lat3_strobe: got %b want 01", {if3.bus_wr_en, if3.bus_rd_en});
        else n_pass++;
        tick();
        n_checks++;
        if ({if3.bus_rd_en, if3.m0_ack} !== 2'b00)
            $display("FAIL lat3_t2: got %b want 00", {if3.bus_rd_en, if3.m0_ack});
        else n_pass++;
        tick();
        if3.bus_rdata = 32'h1234_5678;
        n_checks++;
        if (if3.m0_ack !== 1'b0) $display("FAIL lat3_t3_ack: got %b want 0", if3.m0_ack);
        else n_pass++;
        tick();
        if3.bus_rdata = 32'hDEAD_BEEF;
        n_checks++;
        if (if3.m0_ack !== 1'b1) $display("FAIL lat3_ack: got %b want 1", if3.m0_ack);
        else n_pass++;
        n_checks++;
        if (if3.m0_rdata !== 32'h1234_5678)
            $display("FAIL lat3_rdata: got %h want 12345678", if3.m0_rdata);
        else n_pass++;
        if3.m0_req = 1'b0;
        tick();
        n_checks++;
        if ({if3.busy, if3.m0_ack} !== 2'b00)
            $display("FAIL lat3_idle: got %b want 00", {if3.busy, if3.m0_ack});
        else n_pass++;
        $display("txn lat3 read m0: rdata=%h", if3.m0_rdata);
    endtask

    task automatic test_back_to_back();
        int  c1 = -1;
        int  c2 = -1;
        bit  both_seen = 1'b0;
        if1.m0_req = 1'b1; if1.m0_we = 1'b1; if1.m0_addr = 32'h300; if1.m0_wdata = 32'hC0;
        for (int k = 0; k < 20 && c2 < 0; k++) begin
            tick();
            if (if1.bus_wr_en && if1.bus_rd_en) both_seen = 1'b1;
            if (if1.bus_wr_en) begin
                if (c1 < 0) c1 = k;
                else c2 = k;
            end
        end
        if1.m0_req = 1'b0;
        n_checks++;
        if (c1 < 0 || c2 < 0) $display("FAIL b2b_timeout: got c1=%0d c2=%0d want two strobes", c1, c2);
        else n_pass++;
        n_checks++;
        if (c2 - c1 < 3) $display("FAIL b2b_spacing: got %0d want >=3", c2 - c1);
        else n_pass++;
        n_checks++;
        if (both_seen !== 1'b0) $display("FAIL b2b_both_strobes: got %b want 0", both_seen);
        else n_pass++;
        tick();
        tick();
        tick();
        $display("txn back_to_back m0: spacing=%0d", c2 - c1);
    endtask

    task automatic test_reset_mid();
        if3.bus_rdata = 32'h77;
        if3.m0_req = 1'b1; if3.m0_we = 1'b0; if3.m0_addr = 32'h4000_0020;
        tick();
        tick();
        rst = 1'b1;
        if3.m0_req = 1'b0;
        tick();
        n_checks++;
        if ({if3.busy, if3.owner, if3.bus_wr_en, if3.bus_rd_en, if3.m0_ack, if3.m1_ack} !== 6'b0)
            $display("FAIL rstmid_flags: got %b want 000000", {if3.busy, if3.owner, if3.bus_wr_en, if3.bus_rd_en, if3.m0_ack, if3.m1_ack});
        else n_pass++;
        n_checks++;
        if ({if3.bus_addr, if3.m0_rdata} !== 64'h0)
            $display("FAIL rstmid_regs: got %h want 0", {if3.bus_addr, if3.m0_rdata});
        else n_pass++;
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (if3.m0_ack !== 1'b0) $display("FAIL rstmid_no_ack: got %b want 0", if3.m0_ack);
        else n_pass++;
        if3.bus_rdata = 32'h55;
        if3.m1_req = 1'b1; if3.m1_we = 1'b0; if3.m1_addr = 32'h4000_0024;
        tick();
        n_checks++;
        if ({if3.bus_rd_en, if3.owner} !== 2'b11)
            $display("FAIL rstmid_m1_strobe: got %b want 11", {if3.bus_rd_en, if3.owner});
        else n_pass++;
        tick();
        tick();
        tick();
        n_checks++;
        if ({if3.m1_ack, if3.m0_ack} !== 2'b10)
            $display("FAIL rstmid_m1_ack: got %b want 10", {if3.m1_ack, if3.m0_ack});
        else n_pass++;
        n_checks++;
        if (if3.m1_rdata !== 32'h55) $display("FAIL rstmid_m1_rdata: got %h want 00000055", if3.m1_rdata);
        else n_pass++;
        if3.m1_req = 1'b0;
        tick();
        $display("txn reset_mid then m1 read: rdata=%h", if3.m1_rdata);
    endtask

    initial begin
        if1.m0_req = 1'b0; if1.m0_we = 1'b0; if1.m0_addr = '0; if1.m0_wdata = '0;
        if1.m1_req = 1'b0; if1.m1_we = 1'b0; if1.m1_addr = '0; if1.m1_wdata = '0;
        if1.bus_rdata = '0;
        if3.m0_req = 1'b0; if3.m0_we = 1'b0; if3.m0_addr = '0; if3.m0_wdata = '0;
        if3.m1_req = 1'b0; if3.m1_we = 1'b0; if3.m1_addr = '0; if3.m1_wdata = '0;
        if3.bus_rdata = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_latency3();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
